// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM state type and the transfer-size legality check.
package ahb_pkg;

  typedef enum logic [1:0] {
    AHB_TRANS_IDLE   = 2'b00,
    AHB_TRANS_BUSY   = 2'b01,
    AHB_TRANS_NONSEQ = 2'b10,
    AHB_TRANS_SEQ    = 2'b11
  } ahb_trans_e;

  typedef enum logic [2:0] {
    AHB_BURST_SINGLE = 3'd0,
    AHB_BURST_INCR   = 3'd1,
    AHB_BURST_WRAP4  = 3'd2,
    AHB_BURST_INCR4  = 3'd3,
    AHB_BURST_WRAP8  = 3'd4,
    AHB_BURST_INCR8  = 3'd5,
    AHB_BURST_WRAP16 = 3'd6,
    AHB_BURST_INCR16 = 3'd7
  } ahb_burst_e;

  typedef enum logic {
    AHB_RESP_OKAY  = 1'b0,
    AHB_RESP_ERROR = 1'b1
  } ahb_resp_e;

  typedef enum logic [2:0] {
    AHB_SIZE_8    = 3'd0,
    AHB_SIZE_16   = 3'd1,
    AHB_SIZE_32   = 3'd2,
    AHB_SIZE_64   = 3'd3,
    AHB_SIZE_128  = 3'd4,
    AHB_SIZE_256  = 3'd5,
    AHB_SIZE_512  = 3'd6,
    AHB_SIZE_1024 = 3'd7
  } ahb_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR1   = 2'd2,
    ST_ERR2   = 2'd3
  } slv_state_e;

  // Fixed-width control latched from an accepted address phase
  typedef struct packed {
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
  } ahb_ctrl_t;

  // True when a transfer of the given HSIZE fits in the data bus
  function automatic logic size_valid(input logic [2:0] size, input int unsigned data_width);
    return (32'd8 << size) <= data_width;
  endfunction

endpackage

// File: rtl/ahb_slave_wait_timer.sv
// Counts backend wait cycles of one beat; expired_c flags the last allowed cycle.
module ahb_slave_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Clear has priority so a back-to-back beat starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_c = enable & (cnt_q == CNT_W'(WAIT_LIMIT - 1));

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite responder bridging each NONSEQ/SEQ beat to a valid/ready backend request.
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter int unsigned WAIT_LIMIT     = 16
) (
  input  logic                        ahb_clk_in,
  input  logic                        ahb_rstn_in,
  input  logic                        ahb_sel_in,
  input  logic [AHB_ADDR_WIDTH-1:0]   ahb_addr_in,
  input  logic [1:0]                  ahb_trans_in,
  input  logic                        ahb_write_in,
  input  logic [2:0]                  ahb_size_in,
  input  logic [2:0]                  ahb_burst_in,
  input  logic [3:0]                  ahb_prot_in,
  input  logic [AHB_DATA_WIDTH/8-1:0] ahb_strb_in,
  input  logic [AHB_DATA_WIDTH-1:0]   ahb_wdata_in,
  input  logic                        ahb_ready_in,
  output logic                        ahb_ready_out,
  output logic                        ahb_resp_out,
  output logic [AHB_DATA_WIDTH-1:0]   ahb_rdata_out,
  output logic                        other_clk_out,
  output logic                        other_valid_out,
  output logic [AHB_ADDR_WIDTH-1:0]   other_addr_out,
  output logic                        other_write_out,
  output logic [2:0]                  other_size_out,
  output logic [AHB_DATA_WIDTH/8-1:0] other_strb_out,
  output logic [3:0]                  other_prot_out,
  output logic [AHB_DATA_WIDTH-1:0]   other_wdata_out,
  input  logic                        other_ready_in,
  input  logic                        other_error_in,
  input  logic [AHB_DATA_WIDTH-1:0]   other_rdata_in
);

  localparam int unsigned STRB_W = AHB_DATA_WIDTH / 8;

  slv_state_e                state_q, state_d;
  ahb_ctrl_t                 ctrl_q;
  logic [AHB_ADDR_WIDTH-1:0] addr_q;
  logic [STRB_W-1:0]         strb_q;
  logic [AHB_ADDR_WIDTH-1:0] align_mask;
  logic                      vap_c, beat_ok_c, done_c, load_c, timer_en_c, expired_c;
  logic                      unused_bits;

  assign other_clk_out   = ahb_clk_in;
  assign other_addr_out  = addr_q;
  assign other_write_out = ctrl_q.write;
  assign other_size_out  = ctrl_q.size;
  assign other_strb_out  = strb_q;
  assign other_prot_out  = ctrl_q.prot;

  // Address-phase qualification and beat legality
  assign vap_c      = ahb_sel_in & ahb_ready_in & ahb_trans_in[1];
  assign align_mask = AHB_ADDR_WIDTH'((32'd1 << ahb_size_in) - 32'd1);
  assign beat_ok_c  = size_valid(ahb_size_in, AHB_DATA_WIDTH) &&
                      ((ahb_addr_in & align_mask) == '0);
  assign done_c     = other_ready_in & ~other_error_in;

  // Burst type is kept only for debug visibility; HTRANS[0] does not affect decoding
  assign unused_bits = ^{ctrl_q.burst, ahb_trans_in[0]};

  // State register
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch control of every accepted address phase
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      ctrl_q <= '0;
      addr_q <= '0;
      strb_q <= '0;
    end else if (load_c) begin
      ctrl_q <= '{write: ahb_write_in, size: ahb_size_in, burst: ahb_burst_in, prot: ahb_prot_in};
      addr_q <= ahb_addr_in;
      strb_q <= ahb_strb_in;
    end
  end

  // Next state and bus/backend outputs
  always_comb begin
    state_d         = state_q;
    load_c          = 1'b0;
    timer_en_c      = 1'b0;
    ahb_ready_out   = 1'b1;
    ahb_resp_out    = AHB_RESP_OKAY;
    ahb_rdata_out   = '0;
    other_valid_out = 1'b0;
    other_wdata_out = '0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (state_q == ST_ERR2) ahb_resp_out = AHB_RESP_ERROR;
        if (vap_c) begin
          load_c  = 1'b1;
          state_d = beat_ok_c ? ST_ACCESS : ST_ERR1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        other_valid_out = 1'b1;
        timer_en_c      = 1'b1;
        ahb_ready_out   = done_c;
        if (ctrl_q.write) begin
          other_wdata_out = ahb_wdata_in;
        end else if (done_c) begin
          ahb_rdata_out = other_rdata_in;
        end
        if (done_c) begin
          if (vap_c) begin
            load_c  = 1'b1;
            state_d = beat_ok_c ? ST_ACCESS : ST_ERR1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (other_ready_in || expired_c) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: begin
        ahb_ready_out = 1'b0;
        ahb_resp_out  = AHB_RESP_ERROR;
        state_d       = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  ahb_slave_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk      (ahb_clk_in),
    .rst_n    (ahb_rstn_in),
    .clear    (load_c),
    .enable   (timer_en_c),
    .expired_c(expired_c)
  );

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if with a queue of expected backend beats.
module tb_ahb_slave_if;
  import ahb_pkg::*;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel, write, hready, readyout, resp;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  trans;
  logic [2:0]  size, burst;
  logic [3:0]  prot, strb;
  logic        oclk, ovalid, owrite;
  logic [31:0] oaddr, owdata, be_rdata;
  logic [2:0]  osize;
  logic [3:0]  ostrb, oprot;
  logic        be_ready, be_err;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Single-slave interconnect: HREADY is this slave's HREADYOUT
  assign hready   = readyout;
  // Backend returns its address as read data
  assign be_rdata = oaddr;

  ahb_slave_if #(
    .AHB_ADDR_WIDTH(32),
    .AHB_DATA_WIDTH(32),
    .WAIT_LIMIT    (4)
  ) dut (
    .ahb_clk_in     (clk),
    .ahb_rstn_in    (rst_n),
    .ahb_sel_in     (sel),
    .ahb_addr_in    (addr),
    .ahb_trans_in   (trans),
    .ahb_write_in   (write),
    .ahb_size_in    (size),
    .ahb_burst_in   (burst),
    .ahb_prot_in    (prot),
    .ahb_strb_in    (strb),
    .ahb_wdata_in   (wdata),
    .ahb_ready_in   (hready),
    .ahb_ready_out  (readyout),
    .ahb_resp_out   (resp),
    .ahb_rdata_out  (rdata),
    .other_clk_out  (oclk),
    .other_valid_out(ovalid),
    .other_addr_out (oaddr),
    .other_write_out(owrite),
    .other_size_out (osize),
    .other_strb_out (ostrb),
    .other_prot_out (oprot),
    .other_wdata_out(owdata),
    .other_ready_in (be_ready),
    .other_error_in (be_err),
    .other_rdata_in (be_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    exp_t e;
    n_checks++;
    assert (sb.size() > 0) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty queue expected an entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_addr"}, oaddr, e.addr);
      chk({tag, "_data"}, e.w ? owdata : rdata, e.data);
    end
  endtask

  task automatic drive(input logic [1:0] t, input logic w, input logic [31:0] a,
                       input logic [2:0] s, input logic [2:0] b);
    sel   = (t != AHB_TRANS_IDLE);
    trans = t;
    write = w;
    addr  = a;
    size  = s;
    burst = b;
    prot  = 4'h3;
    strb  = 4'hF;
  endtask

  task automatic bus_idle();
    drive(AHB_TRANS_IDLE, 1'b0, 32'h0, 3'd0, 3'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  err_size [2];
    logic [31:0] err_addr [2];
    err_size[0] = 3'd3; err_addr[0] = 32'h0;
    err_size[1] = 3'd2; err_addr[1] = 32'h2;

    rst_n = 1'b0; be_ready = 1'b0; be_err = 1'b0; wdata = '0;
    bus_idle();

    // Reset values
    smp();
    chk("rst_ready", readyout, 1);
    chk("rst_resp", resp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_valid", ovalid, 0);
    chk("rst_addr", oaddr, 0);
    tick();
    rst_n = 1'b1;

    // Single write, backend ready one cycle late
    tick();
    drive(AHB_TRANS_NONSEQ, 1'b1, 32'h10, 3'd2, AHB_BURST_SINGLE);
    sb.push_back('{1'b1, 32'h10, 32'hA5A5_A5A5});
    smp();
    chk("wr_idle_ready", readyout, 1);
    chk("wr_idle_valid", ovalid, 0);
    tick();
    bus_idle();
    wdata = 32'hA5A5_A5A5;
    smp();
    chk("wr_wait_valid", ovalid, 1);
    chk("wr_wait_addr", oaddr, 32'h10);
    chk("wr_wait_ready", readyout, 0);
    chk("wr_write", owrite, 1);
    chk("wr_size", osize, 2);
    chk("wr_prot", oprot, 3);
    chk("wr_strb", ostrb, 4'hF);
    tick();
    be_ready = 1'b1;
    smp();
    chk("wr_done_valid", ovalid, 1);
    chk("wr_done_ready", readyout, 1);
    chk("wr_done_resp", resp, 0);
    sb_pop("wr");
    tick();
    be_ready = 1'b0;
    wdata = '0;
    smp();
    chk("wr_end_valid", ovalid, 0);
    chk("wr_end_ready", readyout, 1);

    // Back-to-back zero-wait reads
    be_ready = 1'b1;
    tick();
    drive(AHB_TRANS_NONSEQ, 1'b0, 32'h0, 3'd2, AHB_BURST_INCR4);
    sb.push_back('{1'b0, 32'h0, 32'h0});
    smp();
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i < 3) begin
        drive(AHB_TRANS_SEQ, 1'b0, 32'(4 * i), 3'd2, AHB_BURST_INCR4);
        sb.push_back('{1'b0, 32'(4 * i), 32'(4 * i)});
      end else begin
        bus_idle();
      end
      smp();
      chk("rd_ready", readyout, 1);
      sb_pop("rd");
    end
    tick();
    smp();
    chk("rd_end_valid", ovalid, 0);

    // Illegal size / misaligned address: two-cycle ERROR, no backend access
    for (int k = 0; k < 2; k++) begin
      tick();
      drive(AHB_TRANS_NONSEQ, 1'b0, err_addr[k], err_size[k], AHB_BURST_SINGLE);
      smp();
      tick();
      bus_idle();
      smp();
      chk("bad_err1_ready", readyout, 0);
      chk("bad_err1_resp", resp, 1);
      chk("bad_err1_valid", ovalid, 0);
      tick();
      smp();
      chk("bad_err2_ready", readyout, 1);
      chk("bad_err2_resp", resp, 1);
      chk("bad_err2_valid", ovalid, 0);
      tick();
      smp();
      chk("bad_idle_resp", resp, 0);
    end

    // Backend error on beat 2 of an INCR4
    tick();
    drive(AHB_TRANS_NONSEQ, 1'b0, 32'h20, 3'd2, AHB_BURST_INCR4);
    sb.push_back('{1'b0, 32'h20, 32'h20});
    smp();
    tick();
    drive(AHB_TRANS_SEQ, 1'b0, 32'h24, 3'd2, AHB_BURST_INCR4);
    smp();
    chk("be_b1_ready", readyout, 1);
    sb_pop("be_b1");
    tick();
    drive(AHB_TRANS_SEQ, 1'b0, 32'h28, 3'd2, AHB_BURST_INCR4);
    be_err = 1'b1;
    smp();
    chk("be_b2_ready", readyout, 0);
    chk("be_b2_resp", resp, 0);
    chk("be_b2_addr", oaddr, 32'h24);
    tick();
    be_err = 1'b0;
    bus_idle();
    smp();
    chk("be_err1_ready", readyout, 0);
    chk("be_err1_resp", resp, 1);
    chk("be_err1_valid", ovalid, 0);
    tick();
    smp();
    chk("be_err2_ready", readyout, 1);
    chk("be_err2_resp", resp, 1);
    tick();
    smp();
    chk("be_idle_ready", readyout, 1);
    chk("be_idle_resp", resp, 0);
    chk("be_idle_valid", ovalid, 0);

    // Backend never ready: timeout after four wait cycles
    be_ready = 1'b0;
    tick();
    drive(AHB_TRANS_NONSEQ, 1'b1, 32'h40, 3'd2, AHB_BURST_SINGLE);
    smp();
    tick();
    bus_idle();
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("to_wait_ready", readyout, 0);
      chk("to_wait_valid", ovalid, 1);
      tick();
    end
    smp();
    chk("to_err1_ready", readyout, 0);
    chk("to_err1_resp", resp, 1);
    chk("to_err1_valid", ovalid, 0);
    tick();
    smp();
    chk("to_err2_ready", readyout, 1);
    chk("to_err2_resp", resp, 1);
    tick();
    smp();
    chk("to_idle_resp", resp, 0);

    // Asynchronous reset in the middle of a wait
    tick();
    drive(AHB_TRANS_NONSEQ, 1'b0, 32'h50, 3'd2, AHB_BURST_SINGLE);
    smp();
    tick();
    bus_idle();
    smp();
    chk("ar_pre_valid", ovalid, 1);
    chk("ar_pre_addr", oaddr, 32'h50);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", ovalid, 0);
    chk("ar_ready", readyout, 1);
    chk("ar_resp", resp, 0);
    chk("ar_rdata", rdata, 0);
    chk("ar_addr", oaddr, 0);
    tick();
    tick();
    rst_n = 1'b1;
    be_ready = 1'b1;
    drive(AHB_TRANS_NONSEQ, 1'b0, 32'h60, 3'd2, AHB_BURST_SINGLE);
    sb.push_back('{1'b0, 32'h60, 32'h60});
    smp();
    tick();
    bus_idle();
    smp();
    chk("post_rst_ready", readyout, 1);
    sb_pop("post_rst");
    tick();
    smp();
    chk("post_rst_valid", ovalid, 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
AHB-Lite responder; the counterpart of the existing AHB master interface. It accepts address/control phases from the AHB interconnect and turns each NONSEQ/SEQ beat into a single request on a simple valid/ready local backend port (register file or memory). It returns HREADYOUT, HRESP and HRDATA to the bus, including wait states, two-cycle ERROR responses and a backend timeout.

Parameters:
AHB_ADDR_WIDTH, 32, address bus width
AHB_DATA_WIDTH, 32, data bus width (32/64/128)
WAIT_LIMIT, 16, max backend wait cycles before forced ERROR (1..255)

Ports:
ahb_clk_in  in  1  bus clock; other_clk_out is a copy of it
ahb_rstn_in  in  1  async active-low reset
ahb_sel_in  in  1  HSEL
ahb_addr_in  in  AHB_ADDR_WIDTH  HADDR
ahb_trans_in  in  2  HTRANS (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
ahb_write_in  in  1  HWRITE
ahb_size_in  in  3  HSIZE
ahb_burst_in  in  3  HBURST (latched, informational only)
ahb_prot_in  in  4  HPROT
ahb_strb_in  in  AHB_DATA_WIDTH/8  byte strobes, address-phase timed
ahb_wdata_in  in  AHB_DATA_WIDTH  HWDATA, data-phase timed
ahb_ready_in  in  1  HREADY from the interconnect mux
ahb_ready_out  out  1  HREADYOUT
ahb_resp_out  out  1  HRESP (0 OKAY, 1 ERROR)
ahb_rdata_out  out  AHB_DATA_WIDTH  HRDATA
other_clk_out  out  1  = ahb_clk_in
other_valid_out  out  1  backend request
other_addr_out  out  AHB_ADDR_WIDTH  latched address
other_write_out  out  1  latched direction
other_size_out  out  3  latched size
other_strb_out  out  AHB_DATA_WIDTH/8  latched strobes
other_prot_out  out  4  latched prot
other_wdata_out  out  AHB_DATA_WIDTH  = ahb_wdata_in during a write access
other_ready_in  in  1  backend completes the access this cycle
other_error_in  in  1  backend error; qualified by other_ready_in
other_rdata_in  in  AHB_DATA_WIDTH  read data; qualified by other_ready_in

Behaviour:
- Clock ahb_clk_in, asynchronous active-low reset ahb_rstn_in. All state updates on the posedge.
- Reset values: state IDLE, ahb_ready_out=1, ahb_resp_out=0, ahb_rdata_out=0, other_valid_out=0, all latched control=0, timer=0. Reset mid-access drops other_valid_out immediately; the partial beat is abandoned.
- Valid address phase (vap) = ahb_sel_in & ahb_ready_in & ahb_trans_in[1].
- Beat check on vap: ERROR if (8<<size) > AHB_DATA_WIDTH or addr is misaligned (addr & ((1<<size)-1) != 0). Otherwise OKAY.
- States: IDLE, ACCESS, ERR1, ERR2.
- IDLE: ready_out=1, resp=0. On vap: latch the control; go to ERR1 if the beat check fails, else ACCESS. IDLE, BUSY or unselected beats get a zero-wait OKAY and no backend access.
- ACCESS:
  - other_valid_out=1; timer increments each cycle.
  - ready_out = other_ready_in & !other_error_in (combinational); resp=0.
  - rdata_out = other_rdata_in when a read completes, else 0.
  - On other_ready_in & !other_error_in: the beat completes. Next state is the vap rule above (pipelined back-to-back, no bubble), else IDLE.
  - On other_ready_in & other_error_in, or timer == WAIT_LIMIT-1 without ready: go to ERR1; other_valid_out drops next cycle.
- ERR1: ready_out=0, resp=1. Next state is always ERR2.
- ERR2: ready_out=1, resp=1. The address phase presented now is sampled by the vap rule. Master may cancel with IDLE → IDLE.
- Timer clears on entry to ACCESS. Width is ceil(log2(WAIT_LIMIT+1)).
- SEQ beats are treated exactly like NONSEQ; no burst address prediction; wrap/incr legality is the master's job.
- Simultaneous backend ready and timeout expiry: ready wins.
- other_ready_in outside ACCESS is ignored.
- ahb_ready_in low while in IDLE: no sampling.

Decomposition:
- Shared package ahb_pkg: AHB_TRANS_* (IDLE/BUSY/NONSEQ/SEQ), AHB_BURST_* (SINGLE..INCR16), AHB_RESP_OKAY/ERROR, size codes, and a size_valid function of (size, data width). The existing master moves to the same package.
- One sub-module: ahb_slave_wait_timer (clear, enable, expired output at WAIT_LIMIT-1).

Test Plan:
- Reset, then NONSEQ write addr 0x10, size 2, wdata 0xA5A5A5A5, backend ready next cycle → other_valid_out 1 for 2 cycles, other_addr_out=0x10, ready_out low 1 cycle, resp 0.
- Back-to-back zero-wait reads 0x0, 0x4, 0x8 (INCR4 first three beats), backend ready combinationally with rdata=addr → ready_out stays 1, rdata 0x0, 0x4, 0x8 on consecutive cycles.
- Size 3 on 32-bit bus, or size 2 at addr 0x2 → no backend request; ready/resp = 0/1 then 1/1.
- Backend asserts other_error_in with other_ready_in on beat 2 of 4 → two-cycle ERROR; master's IDLE in ERR2 → IDLE state, ready 1, resp 0.
- Backend never ready, WAIT_LIMIT=4 → ready_out low 4 cycles, then ERR1/ERR2, other_valid_out deasserts.
- Assert ahb_rstn_in low mid-wait → all outputs take reset values asynchronously; the first transfer after release completes normally.
